// File: rtl/tmp_result_reader_pkg.sv
// Shared types and helpers for the temperature-sensor result reader.
// Holds the reader state encoding and the src_n/snk strobe decode.
package tmp_pkg;

    localparam int WINDOW_LOG2_DFLT = 4;
    localparam int CODE_W_DFLT      = 12;
    localparam int ACC_W            = WINDOW_LOG2_DFLT + 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_ACCUM,
        ST_PUBLISH
    } rd_state_t;

    typedef struct packed {
        logic signed [1:0] step;
        logic              conflict;
    } strobe_t;

    // src_n is active low: a source pulls the balance down, a sink pushes it up.
    function automatic strobe_t decode_strobe(input logic src_n, input logic snk);
        strobe_t r;
        r.step     = 2'sd0;
        r.conflict = 1'b0;
        case ({src_n, snk})
            2'b11:   r.step     = 2'sd1;
            2'b00:   r.step     = -2'sd1;
            2'b01:   r.conflict = 1'b1;
            default: r.step     = 2'sd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tmp_result_reader_if.sv
// Valid/ready result channel from the reader to the readout logic.
interface tmp_result_reader_if
    import tmp_pkg::*;
#(
    parameter int CODE_W = CODE_W_DFLT
);
    logic signed [CODE_W-1:0] code;
    logic                     code_valid;
    logic                     code_ready;

    modport master (output code, output code_valid, input code_ready);
    modport slave  (input code, input code_valid, output code_ready);
endinterface

// File: rtl/tmp_result_reader_out_reg.sv
// Result holding register: keeps code stable until accepted, flags a
// result that is replaced while still unaccepted.
module tmp_out_reg
    import tmp_pkg::*;
#(
    parameter int CODE_W = CODE_W_DFLT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load,
    input  logic signed [CODE_W-1:0] din,
    tmp_result_reader_if.master      out_if,
    output logic                     overrun
);

    logic signed [CODE_W-1:0] code_q, code_d;
    logic                     valid_q, valid_d;
    logic                     overrun_q, overrun_d;

    // A load on the accepting edge replaces the accepted code, so it is not an overrun.
    always_comb begin
        code_d    = code_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (load) begin
            code_d  = din;
            valid_d = 1'b1;
            if (valid_q && !out_if.code_ready) begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && out_if.code_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            code_q    <= code_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign out_if.code       = code_q;
    assign out_if.code_valid = valid_q;
    assign overrun           = overrun_q;

endmodule

// File: rtl/tmp_result_reader.sv
// Accumulates the charge-balance strobes over a window of pi2 samples
// and publishes the signed temperature code through a valid/ready channel.
module tmp_result_reader
    import tmp_pkg::*;
#(
    parameter int WINDOW_LOG2 = WINDOW_LOG2_DFLT,
    parameter int CODE_W      = CODE_W_DFLT
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                en,
    input  logic                pre_chrg,
    input  logic                pi2,
    input  logic                src_n,
    input  logic                snk,
    tmp_result_reader_if.master out_if,
    output logic                overrun,
    output logic                conflict
);

    localparam int AW    = WINDOW_LOG2 + 2;
    localparam int CNT_W = WINDOW_LOG2 + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << WINDOW_LOG2) - 1);

    if (CODE_W < WINDOW_LOG2 + 2) begin : g_bad_code_w
        $error("CODE_W must be at least WINDOW_LOG2+2");
    end

    logic [1:0] rst_sync_q;
    logic       rst_n;

    // Assertion is immediate through the flop clears; release waits two clocks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end
    assign rst_n = rst_sync_q[1];

    rd_state_t                state_q, state_d;
    logic signed [AW-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     conflict_q, conflict_d;
    logic                     pi2_q, pre_chrg_q;
    logic                     pub_q;
    logic signed [CODE_W-1:0] pub_code_q;

    strobe_t           st;
    logic signed [1:0] step_s;
    logic              sample;
    logic              pre_fall;

    assign st       = decode_strobe(src_n, snk);
    assign step_s   = st.step;
    assign sample   = pi2 & ~pi2_q;
    assign pre_fall = pre_chrg_q & ~pre_chrg;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        conflict_d = conflict_q;
        case (state_q)
            ST_IDLE: begin
                acc_d = '0;
                cnt_d = '0;
                if (en) begin
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else if (pre_fall) begin
                    state_d = ST_ACCUM;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            ST_ACCUM: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else if (pre_chrg) begin
                    state_d = ST_ARM;
                    acc_d   = '0;
                    cnt_d   = '0;
                end else if (sample) begin
                    acc_d      = acc_q + AW'(step_s);
                    cnt_d      = cnt_q + CNT_W'(1);
                    conflict_d = conflict_q | st.conflict;
                    if (cnt_q == LAST_CNT) begin
                        state_d = ST_PUBLISH;
                    end
                end
            end
            ST_PUBLISH: begin
                acc_d   = '0;
                cnt_d   = '0;
                state_d = en ? ST_ACCUM : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            conflict_q <= 1'b0;
            pi2_q      <= 1'b0;
            pre_chrg_q <= 1'b0;
            pub_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            conflict_q <= conflict_d;
            pi2_q      <= pi2;
            pre_chrg_q <= pre_chrg;
            pub_q      <= (state_q == ST_PUBLISH);
        end
    end

    // Publish stage: the window sum is captured while the accumulator restarts.
    always_ff @(posedge clk) begin
        if (state_q == ST_PUBLISH) begin
            pub_code_q <= CODE_W'(acc_q);
        end
    end

    tmp_out_reg #(
        .CODE_W (CODE_W)
    ) u_out_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (pub_q),
        .din     (pub_code_q),
        .out_if  (out_if),
        .overrun (overrun)
    );

    assign conflict = conflict_q;

endmodule

// File: tb/tb_tmp_result_reader.sv
// Directed-sequence bench with randomized sample ordering; expected codes
// come from counting sinks and sources in each window.
module tb_tmp_result_reader;

    localparam int WL  = 4;
    localparam int CW  = 12;
    localparam int WIN = 1 << WL;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n, en, pre_chrg, pi2, src_n, snk;
    logic overrun, conflict;

    tmp_result_reader_if #(.CODE_W(CW)) rif ();

    logic [CW-1:0] code_u;
    assign code_u = rif.code;

    tmp_result_reader #(
        .WINDOW_LOG2 (WL),
        .CODE_W      (CW)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (en),
        .pre_chrg (pre_chrg),
        .pi2      (pi2),
        .src_n    (src_n),
        .snk      (snk),
        .out_if   (rif),
        .overrun  (overrun),
        .conflict (conflict)
    );

    int checks = 0;
    int errors = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // kind: 0 sink, 1 source, 2 idle, 3 both strobes (conflict)
    task automatic drive_sample(input int kind);
        case (kind)
            0:       begin src_n = 1'b1; snk = 1'b1; end
            1:       begin src_n = 1'b0; snk = 1'b0; end
            2:       begin src_n = 1'b1; snk = 1'b0; end
            default: begin src_n = 1'b0; snk = 1'b1; end
        endcase
        pi2 = 1'b1;
        tick();
        pi2   = 1'b0;
        src_n = 1'b1;
        snk   = 1'b0;
        tick();
    endtask

    task automatic precharge;
        pre_chrg = 1'b1;
        tick();
        pre_chrg = 1'b0;
        tick();
        tick();
    endtask

    // Drives one full window in random order and checks the published result.
    task automatic run_window(input string tag, input int n_sink, input int n_src,
                              input int n_conf, input bit check_idle);
        int kinds [WIN];
        int j, t, exp_val;
        logic [CW-1:0] e;
        for (int i = 0; i < WIN; i++) begin
            if (i < n_sink)                      kinds[i] = 0;
            else if (i < n_sink + n_src)         kinds[i] = 1;
            else if (i < n_sink + n_src + n_conf) kinds[i] = 3;
            else                                 kinds[i] = 2;
        end
        for (int i = WIN - 1; i > 0; i--) begin
            j        = int'($urandom_range(i, 0));
            t        = kinds[i];
            kinds[i] = kinds[j];
            kinds[j] = t;
        end
        for (int i = 0; i < WIN; i++) begin
            drive_sample(kinds[i]);
        end
        exp_val = n_sink - n_src;
        e       = CW'(exp_val);
        if (check_idle) begin
            chk({tag, "_early"}, 32'(rif.code_valid), 32'd0);
        end
        tick();
        chk({tag, "_valid"}, 32'(rif.code_valid), 32'd1);
        chk({tag, "_code"}, 32'(code_u), 32'(e));
        if (rif.code_ready) begin
            tick();
            chk({tag, "_drop"}, 32'(rif.code_valid), 32'd0);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        int ns, nsr, nc;
        reset_n        = 1'b0;
        en             = 1'b0;
        pre_chrg       = 1'b0;
        pi2            = 1'b0;
        src_n          = 1'b1;
        snk            = 1'b0;
        rif.code_ready = 1'b1;
        repeat (3) tick();
        chk("rst_code", 32'(code_u), 32'd0);
        chk("rst_valid", 32'(rif.code_valid), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_conflict", 32'(conflict), 32'd0);

        reset_n = 1'b1;
        repeat (3) tick();
        en = 1'b1;
        tick();
        precharge();

        run_window("all_sink", 16, 0, 0, 1'b1);
        run_window("mix", 10, 6, 0, 1'b1);
        run_window("all_src", 0, 16, 0, 1'b1);
        chk("all_src_hex", 32'(code_u), 32'h0FF0);

        rif.code_ready = 1'b0;
        run_window("hold_a", 5, 3, 0, 1'b1);
        tick();
        chk("hold_a_kept_valid", 32'(rif.code_valid), 32'd1);
        chk("hold_a_kept_code", 32'(code_u), 32'd2);
        chk("hold_a_no_overrun", 32'(overrun), 32'd0);
        run_window("hold_b", 3, 5, 0, 1'b0);
        chk("overrun_set", 32'(overrun), 32'd1);
        rif.code_ready = 1'b1;
        tick();
        chk("accept_clears", 32'(rif.code_valid), 32'd0);
        chk("overrun_sticky", 32'(overrun), 32'd1);

        for (int i = 0; i < 7; i++) begin
            drive_sample(0);
        end
        precharge();
        repeat (4) tick();
        chk("abort_no_publish", 32'(rif.code_valid), 32'd0);
        run_window("post_abort", 16, 0, 0, 1'b1);

        chk("conflict_clear", 32'(conflict), 32'd0);
        run_window("conflict", 15, 0, 1, 1'b1);
        chk("conflict_set", 32'(conflict), 32'd1);

        for (int r = 0; r < 3; r++) begin
            ns  = int'($urandom_range(16, 0));
            nsr = int'($urandom_range(16 - ns, 0));
            nc  = int'($urandom_range(16 - ns - nsr, 0));
            run_window("rand", ns, nsr, nc, 1'b1);
            chk("conflict_sticky", 32'(conflict), 32'd1);
        end

        rif.code_ready = 1'b0;
        run_window("pre_rst", 4, 1, 0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive_sample(0);
        end
        reset_n = 1'b0;
        #2;
        chk("async_rst_code", 32'(code_u), 32'd0);
        chk("async_rst_valid", 32'(rif.code_valid), 32'd0);
        chk("async_rst_overrun", 32'(overrun), 32'd0);
        chk("async_rst_conflict", 32'(conflict), 32'd0);
        repeat (2) tick();
        reset_n        = 1'b1;
        rif.code_ready = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < WIN; i++) begin
            drive_sample(0);
        end
        repeat (4) tick();
        chk("no_code_without_prechrg", 32'(rif.code_valid), 32'd0);
        precharge();
        ns  = int'($urandom_range(16, 0));
        nsr = 16 - ns;
        run_window("after_rst", ns, nsr, 0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
